// File: rtl/mcca_pkg.sv
// Shared definitions for the chunked Manchester carry-chain adder front end:
// state encoding, default geometry and chunk-count helpers.
package mcca_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DEF_WIDTH   = 64;
   localparam int DEF_CHUNK_W = 16;

   function automatic int nchunk(input int width, input int chunk_w);
      return width / chunk_w;
   endfunction

   // A one-chunk configuration still needs a 1-bit index register.
   function automatic int idx_bits(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mcca_chunk_sequencer_adder.sv
// Chunk adder: Manchester carry chain built from 4-bit propagate/generate
// groups, purely combinational.
module AdderBlock64bit #(
   parameter int size = 16
) (
   input  logic [size-1:0] i_a,
   input  logic [size-1:0] i_b,
   input  logic            i_cin,
   output logic [size-1:0] o_sum,
   output logic            o_cout
);

   localparam int NG = size / 4;

   logic [size-1:0] w_p;
   logic [size-1:0] w_g;
   logic [size:0]   w_c;
   logic [NG-1:0]   w_grp_p;
   logic [NG-1:0]   w_grp_g;

   assign w_p = i_a ^ i_b;
   assign w_g = i_a & i_b;

   // Group terms let the carry bypass a nibble whose four bits all propagate.
   always_comb begin
      w_grp_p = '0;
      w_grp_g = '0;
      for (int j = 0; j < NG; j++) begin
         w_grp_p[j] = &w_p[4*j +: 4];
         w_grp_g[j] = w_g[4*j+3]
                    | (w_p[4*j+3] & w_g[4*j+2])
                    | (w_p[4*j+3] & w_p[4*j+2] & w_g[4*j+1])
                    | (w_p[4*j+3] & w_p[4*j+2] & w_p[4*j+1] & w_g[4*j]);
      end
   end

   always_comb begin
      w_c    = '0;
      w_c[0] = i_cin;
      for (int j = 0; j < NG; j++) begin
         for (int k = 0; k < 3; k++) begin
            w_c[4*j+k+1] = w_g[4*j+k] | (w_p[4*j+k] & w_c[4*j+k]);
         end
         w_c[4*j+4] = w_grp_g[j] | (w_grp_p[j] & w_c[4*j]);
      end
   end

   assign o_sum  = w_p ^ w_c[size-1:0];
   assign o_cout = w_c[size];

endmodule

// File: rtl/mcca_chunk_sequencer.sv
// Wide-operand add sequenced through one CHUNK_W-bit carry-chain adder, LSB
// chunk first. Define MCCA_SEQ_OVF_EN to add the registered signed-overflow output out_ovf.
module mcca_chunk_sequencer
   import mcca_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int CHUNK_W = DEF_CHUNK_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             busy
`ifdef MCCA_SEQ_OVF_EN
   ,
   output logic             out_ovf
`endif
);

   localparam int NCHUNK = nchunk(WIDTH, CHUNK_W);
   localparam int IDX_W  = idx_bits(NCHUNK);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

   if (CHUNK_W < 4 || (CHUNK_W % 4) != 0) begin : g_bad_chunk_w
      $error("mcca_chunk_sequencer: CHUNK_W must be >= 4 and a multiple of 4");
   end
   if ((WIDTH % CHUNK_W) != 0 || WIDTH < CHUNK_W) begin : g_bad_width
      $error("mcca_chunk_sequencer: WIDTH must be a multiple of CHUNK_W");
   end

   state_t             r_state;
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   logic [WIDTH-1:0]   r_sum;
   logic [IDX_W-1:0]   r_idx;
   logic               r_carry;
   logic               r_cout;
   logic               r_out_valid;
   logic               r_busy;
   logic [CHUNK_W-1:0] w_chunk_sum;
   logic               w_chunk_cout;
   logic               w_accept;
   logic               w_last;

   assign in_ready  = (r_state == IDLE) && !rst;
   assign w_accept  = in_valid && in_ready;
   assign w_last    = (r_idx == LAST_IDX);

   AdderBlock64bit #(
      .size (CHUNK_W)
   ) u_chunk_adder (
      .i_a    (r_a[CHUNK_W-1:0]),
      .i_b    (r_b[CHUNK_W-1:0]),
      .i_cin  (r_carry),
      .o_sum  (w_chunk_sum),
      .o_cout (w_chunk_cout)
   );

   // Operand shift registers carry no reset: they are only read during ADD,
   // which is always preceded by a load.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_a <= in_a;
         r_b <= in_b;
      end else if (r_state == ADD) begin
         r_a <= r_a >> CHUNK_W;
         r_b <= r_b >> CHUNK_W;
      end
   end

`ifdef MCCA_SEQ_OVF_EN
   logic r_ovf;
   logic w_carry_into_msb;

   // Carry entering the top bit is recovered from its sum bit: s = a ^ b ^ c.
   assign w_carry_into_msb = r_a[CHUNK_W-1] ^ r_b[CHUNK_W-1] ^ w_chunk_sum[CHUNK_W-1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ovf <= 1'b0;
      end else if (r_state == ADD && w_last) begin
         r_ovf <= w_chunk_cout ^ w_carry_into_msb;
      end
   end

   assign out_ovf = r_ovf;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_sum       <= '0;
         r_idx       <= '0;
         r_carry     <= 1'b0;
         r_cout      <= 1'b0;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_carry <= in_cin;
                  r_idx   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= ADD;
               end
            end
            ADD: begin
               r_carry <= w_chunk_cout;
               for (int k = 0; k < NCHUNK; k++) begin
                  if (r_idx == IDX_W'(k)) begin
                     r_sum[k*CHUNK_W +: CHUNK_W] <= w_chunk_sum;
                  end
               end
               if (w_last) begin
                  r_cout      <= w_chunk_cout;
                  r_out_valid <= 1'b1;
                  r_state     <= DONE;
               end else begin
                  r_idx <= r_idx + 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_busy      <= 1'b0;
                  r_state     <= IDLE;
               end
            end
            default: begin
               r_out_valid <= 1'b0;
               r_busy      <= 1'b0;
               r_state     <= IDLE;
            end
         endcase
      end
   end

   assign out_valid = r_out_valid;
   assign out_sum   = r_sum;
   assign out_cout  = r_cout;
   assign busy      = r_busy;

endmodule

// File: doc/mcca_chunk_sequencer.md
# mcca_chunk_sequencer

Multi-cycle wide-operand adder front end for the Manchester carry-chain adder. It accepts two WIDTH-bit operands through a valid/ready handshake and feeds them to one CHUNK_W-bit carry-chain adder one chunk per cycle, LSB chunk first. The chunk carry-out is registered and fed back as the next chunk's carry-in. The assembled WIDTH-bit sum and final carry are returned through a second valid/ready handshake, so downstream logic can consume a wide result from a narrow adder.

## Interface
- WIDTH, 64: operand/result width; must be a multiple of CHUNK_W (elaboration error otherwise).
- CHUNK_W, 16: adder chunk width; must be ≥4 and a multiple of 4.
- clk  input  1  single clock, rising edge.
- rst  input  1  reset, asynchronous and active-high.
- in_valid  input  1  operand request.
- in_ready  output  1  high only in IDLE with rst deasserted.
- in_a, in_b  input  WIDTH  operands, sampled on accept.
- in_cin  input  1  carry-in, sampled on accept.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- out_sum  output  WIDTH  registered sum.
- out_cout  output  1  registered final carry.
- busy  output  1  high in ADD or DONE.

## Operation
- States: IDLE, ADD, DONE. Encoding is 2-bit: IDLE=0, ADD=1, DONE=2.
- IDLE:
  - in_valid && in_ready loads in_a and in_b into operand shift registers, carry_q=in_cin, idx=0, and moves to ADD.
- ADD, each cycle:
  - Feed the low CHUNK_W bits of both operand registers and carry_q to the adder.
  - Write the chunk sum into out_sum[idx*CHUNK_W +: CHUNK_W].
  - carry_q ← chunk cout.
  - Shift the operand registers right by CHUNK_W.
  - idx+1.
  - At idx=NCHUNK-1, move to DONE. NCHUNK=WIDTH/CHUNK_W.
- DONE:
  - out_valid=1, out_cout=carry_q.
  - out_sum and out_cout are held stable until out_valid && out_ready, then move to IDLE.
- idx is ceil(log2(NCHUNK))-bit wide. The sequence never wraps mid-operation. idx clears on accept.
- in_valid outside IDLE is ignored. No queuing.
- No same-cycle accept on the DONE exit. The next accept happens earliest one cycle later in IDLE.
- Arithmetic is unsigned modulo 2^WIDTH. out_cout is the true carry out of bit WIDTH-1.

## Timing
- Reset (async assert, sync deassert handled upstream):
  - state=IDLE, out_valid=0, out_sum=0, out_cout=0, busy=0, carry_q=0, idx=0.
  - in_ready=0 while rst is high.
- Latency: with accept at edge T, out_valid rises after edge T+NCHUNK. For the defaults that is 4 cycles.
- Throughput: one operation per NCHUNK+2 cycles with out_ready tied high.
- rst during ADD or DONE: the operation is aborted with no partial result. in_ready=1 in the first cycle after rst deasserts.
- The chunk adder path is combinational within one cycle. Its outputs are registered only into out_sum and carry_q.

## Configuration
- MCCA_SEQ_OVF_EN defined:
  - Adds output out_ovf (1 bit), the signed overflow, registered with the final chunk.
  - out_ovf = out_cout XOR (carry into bit WIDTH-1), where carry-in = a[W-1]^b[W-1]^sum[W-1] of the last chunk.
  - Reset 0. Valid only while out_valid.
- Undefined: no out_ovf port and no extra logic.

## Structure
- Shared package mcca_pkg holds:
  - the state encoding constants (IDLE/ADD/DONE);
  - the default WIDTH and CHUNK_W;
  - the NCHUNK derivation.
- One sub-module: AdderBlock64bit instantiated with size=CHUNK_W as the chunk adder. No other hierarchy.

## Test plan
- Carry ripple across a chunk: a=0x0000_0000_0000_FFFF, b=0x1, cin=0 → out_sum=0x0000_0000_0001_0000, out_cout=0. out_valid exactly 4 cycles after accept.
- Full carry ripple: a=0xFFFF_FFFF_FFFF_FFFF, b=0, cin=1 → out_sum=0, out_cout=1. With MCCA_SEQ_OVF_EN, out_ovf=0.
- Signed overflow (macro on): a=0x7FFF_FFFF_FFFF_FFFF, b=1, cin=0 → out_sum=0x8000_0000_0000_0000, out_cout=0, out_ovf=1.
- Backpressure: out_ready=0 for 5 cycles in DONE → out_valid stays 1 and out_sum/out_cout stay stable. in_ready=0, and a concurrent in_valid is ignored (no second result).
- Reset mid-op: assert rst after 2 chunks → out_valid=0, out_sum=0, busy=0 immediately. After release, in_ready=1. A fresh add of 0x1234+0x1 returns 0x1235.
- Streaming: in_valid and out_ready held high with random operands → one accept every 6 cycles. Every result matches a+b+cin modulo 2^64 with the correct cout.
